// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: instruction field encodings,
// execute-unit command codes, condition codes and the condition evaluator.
package decode_stage_pkg;

  typedef enum logic [1:0] {
    MODE_ARITH  = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // ARM data-processing opcodes (instr[24:21])
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Execute-unit commands
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  // Condition codes (instr[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // flags = {N, Z, C, V}; code 1111 never passes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic pass;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file_bypass.sv
// Register file with one write port and two combinational read ports.
// A read of the register being written in the same cycle returns the
// write data, so the decode stage sees write-back results without a gap.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears all entries)
//   we, waddr, wdata    write port, written on the rising edge
//   raddr1/rdata1       read port 1 (Rn)
//   raddr2/rdata2       read port 2 (Rm / Rd for stores)
module reg_file_bypass #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int RA_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [RA_W-1:0]   raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
  assign rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage for an ARM-subset pipeline.
// Decodes the presented instruction, evaluates its condition against the
// NZCV flags, reads operands (with write-back bypass), detects RAW hazards
// against the EX and MEM destinations, and registers the result toward EX
// under a valid/ready handshake.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   in_valid/in_ready, instruction, pc_in   upstream handshake and payload
//   sr                                NZCV flags {N,Z,C,V}
//   wb_en_in, wb_dest, wb_result      register write-back
//   exe_wb_en/exe_dest, mem_wb_en/mem_dest  downstream destinations
//   flush                             kill stage contents and presented instruction
//   out_valid/out_ready               downstream handshake
//   wb_en..src2                       registered decoded fields
//   hazard_stall                      combinational data-hazard flag
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int RA_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        sr,
  input  logic              wb_en_in,
  input  logic [RA_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              exe_wb_en,
  input  logic [RA_W-1:0]   exe_dest,
  input  logic              mem_wb_en,
  input  logic [RA_W-1:0]   mem_dest,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic              imm,
  output logic              two_src,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] pc_out,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm_24,
  output logic [RA_W-1:0]   dest,
  output logic [RA_W-1:0]   src1,
  output logic [RA_W-1:0]   src2,
  output logic              hazard_stall
);

  mode_e             mode;
  logic [3:0]        opcode;
  logic              s_bit;
  logic              imm_bit;
  logic              is_str;
  logic              rn_read;
  logic              cond_ok;
  ctrl_t             dec_ctrl;
  ctrl_t             ctrl_d;
  logic [RA_W-1:0]   src1_d;
  logic [RA_W-1:0]   src2_d;
  logic [RA_W-1:0]   dest_d;
  logic              two_src_d;
  logic [DATA_W-1:0] rn_data;
  logic [DATA_W-1:0] rm_data;
  logic              hz_exe;
  logic              hz_mem;
  logic              advance;
  logic              load;

  assign mode    = mode_e'(instruction[27:26]);
  assign opcode  = instruction[24:21];
  assign s_bit   = instruction[20];
  assign imm_bit = instruction[25];
  assign is_str  = (mode == MODE_MEM) && !s_bit;

  assign src1_d    = RA_W'(instruction[19:16]);
  assign dest_d    = RA_W'(instruction[15:12]);
  // Stores read the data register through the second port
  assign src2_d    = is_str ? RA_W'(instruction[15:12]) : RA_W'(instruction[3:0]);
  assign two_src_d = ((mode == MODE_ARITH) && !imm_bit) || is_str;

  always_comb begin
    dec_ctrl = CTRL_NONE;
    rn_read  = 1'b1;
    case (mode)
      MODE_ARITH: begin
        dec_ctrl.s     = s_bit;
        dec_ctrl.wb_en = 1'b1;
        case (opcode)
          OP_MOV: begin dec_ctrl.exe_cmd = EXE_MOV; rn_read = 1'b0; end
          OP_MVN: begin dec_ctrl.exe_cmd = EXE_MVN; rn_read = 1'b0; end
          OP_ADD: dec_ctrl.exe_cmd = EXE_ADD;
          OP_ADC: dec_ctrl.exe_cmd = EXE_ADC;
          OP_SUB: dec_ctrl.exe_cmd = EXE_SUB;
          OP_SBC: dec_ctrl.exe_cmd = EXE_SBC;
          OP_AND: dec_ctrl.exe_cmd = EXE_AND;
          OP_ORR: dec_ctrl.exe_cmd = EXE_ORR;
          OP_EOR: dec_ctrl.exe_cmd = EXE_EOR;
          OP_CMP: begin dec_ctrl.exe_cmd = EXE_SUB; dec_ctrl.wb_en = 1'b0; end
          OP_TST: begin dec_ctrl.exe_cmd = EXE_AND; dec_ctrl.wb_en = 1'b0; end
          default: dec_ctrl = CTRL_NONE;
        endcase
      end
      MODE_MEM: begin
        dec_ctrl.exe_cmd = EXE_ADD;
        if (s_bit) begin
          dec_ctrl.mem_r_en = 1'b1;
          dec_ctrl.wb_en    = 1'b1;
        end else begin
          dec_ctrl.mem_w_en = 1'b1;
        end
      end
      MODE_BRANCH: begin
        dec_ctrl.b = 1'b1;
        rn_read    = 1'b0;
      end
      default: dec_ctrl = CTRL_NONE;
    endcase
  end

  assign cond_ok = cond_pass(instruction[31:28], sr);
  // A failed condition still flows down the pipe as a valid no-op
  assign ctrl_d  = cond_ok ? dec_ctrl : CTRL_NONE;

  assign hz_exe = exe_wb_en && ((rn_read && (exe_dest == src1_d)) ||
                                (two_src_d && (exe_dest == src2_d)));
  assign hz_mem = mem_wb_en && ((rn_read && (mem_dest == src1_d)) ||
                                (two_src_d && (mem_dest == src2_d)));
  assign hazard_stall = in_valid && (hz_exe || hz_mem);

  assign advance  = !out_valid || out_ready;
  assign in_ready = flush || (!hazard_stall && advance);
  assign load     = in_valid && !hazard_stall && advance && !flush;

  reg_file_bypass #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .RA_W   (RA_W)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en_in),
    .waddr  (wb_dest),
    .wdata  (wb_result),
    .raddr1 (src1_d),
    .rdata1 (rn_data),
    .raddr2 (src2_d),
    .rdata2 (rm_data)
  );

  // Flush, bubble and an empty advance all leave a cleared, invalid register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      wb_en         <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      imm           <= 1'b0;
      two_src       <= 1'b0;
      exe_cmd       <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      pc_out        <= '0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      dest          <= '0;
      src1          <= '0;
      src2          <= '0;
    end else if (load) begin
      out_valid     <= 1'b1;
      wb_en         <= ctrl_d.wb_en;
      mem_r_en      <= ctrl_d.mem_r_en;
      mem_w_en      <= ctrl_d.mem_w_en;
      b             <= ctrl_d.b;
      s             <= ctrl_d.s;
      imm           <= imm_bit;
      two_src       <= two_src_d;
      exe_cmd       <= ctrl_d.exe_cmd;
      val_rn        <= rn_data;
      val_rm        <= rm_data;
      pc_out        <= pc_in;
      shift_operand <= instruction[11:0];
      signed_imm_24 <= instruction[23:0];
      dest          <= dest_d;
      src1          <= src1_d;
      src2          <= src2_d;
    end else if (flush || advance) begin
      out_valid     <= 1'b0;
      wb_en         <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      imm           <= 1'b0;
      two_src       <= 1'b0;
      exe_cmd       <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      pc_out        <= '0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      dest          <= '0;
      src1          <= '0;
      src2          <= '0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc_in;
  logic [3:0]  sr;
  logic        wb_en_in;
  logic [3:0]  wb_dest;
  logic [31:0] wb_result;
  logic        exe_wb_en;
  logic [3:0]  exe_dest;
  logic        mem_wb_en;
  logic [3:0]  mem_dest;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic        wb_en, mem_r_en, mem_w_en, b, s, imm, two_src;
  logic [3:0]  exe_cmd;
  logic [31:0] val_rn, val_rm, pc_out;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest, src1, src2;
  logic        hazard_stall;

  int n_assert = 0;
  int n_fail   = 0;

  decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instruction   (instruction),
    .pc_in         (pc_in),
    .sr            (sr),
    .wb_en_in      (wb_en_in),
    .wb_dest       (wb_dest),
    .wb_result     (wb_result),
    .exe_wb_en     (exe_wb_en),
    .exe_dest      (exe_dest),
    .mem_wb_en     (mem_wb_en),
    .mem_dest      (mem_dest),
    .flush         (flush),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .wb_en         (wb_en),
    .mem_r_en      (mem_r_en),
    .mem_w_en      (mem_w_en),
    .b             (b),
    .s             (s),
    .imm           (imm),
    .two_src       (two_src),
    .exe_cmd       (exe_cmd),
    .val_rn        (val_rn),
    .val_rm        (val_rm),
    .pc_out        (pc_out),
    .shift_operand (shift_operand),
    .signed_imm_24 (signed_imm_24),
    .dest          (dest),
    .src1          (src1),
    .src2          (src2),
    .hazard_stall  (hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; instruction = '0; pc_in = '0; sr = '0;
    wb_en_in = 1'b0; wb_dest = '0; wb_result = '0;
    exe_wb_en = 1'b0; exe_dest = '0; mem_wb_en = 1'b0; mem_dest = '0;
    flush = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_wb_en", 32'(wb_en), 32'h0);
    chk("rst_val_rn", val_rn, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b1;

    // write-back R1=5, R3=7
    wb_en_in = 1'b1; wb_dest = 4'd1; wb_result = 32'd5;
    step();
    wb_dest = 4'd3; wb_result = 32'd7;
    step();
    wb_en_in = 1'b0;

    // ADD R2,R1,#3
    in_valid = 1'b1; instruction = 32'hE2812003; pc_in = 32'h100; sr = 4'b0000;
    #1;
    chk("add_imm_in_ready", 32'(in_ready), 32'h1);
    chk("add_imm_no_hazard", 32'(hazard_stall), 32'h0);
    step();
    chk("add_imm_out_valid", 32'(out_valid), 32'h1);
    chk("add_imm_exe_cmd", 32'(exe_cmd), 32'h2);
    chk("add_imm_wb_en", 32'(wb_en), 32'h1);
    chk("add_imm_val_rn", val_rn, 32'd5);
    chk("add_imm_dest", 32'(dest), 32'd2);
    chk("add_imm_imm", 32'(imm), 32'h1);
    chk("add_imm_two_src", 32'(two_src), 32'h0);
    chk("add_imm_shift_op", 32'(shift_operand), 32'h003);
    chk("add_imm_pc_out", pc_out, 32'h100);

    // ADDEQ: fails with Z=0, passes with Z=1
    instruction = 32'h02812003; sr = 4'b0000;
    step();
    chk("addeq_fail_out_valid", 32'(out_valid), 32'h1);
    chk("addeq_fail_wb_en", 32'(wb_en), 32'h0);
    chk("addeq_fail_exe_cmd", 32'(exe_cmd), 32'h0);
    sr = 4'b0100;
    step();
    chk("addeq_pass_wb_en", 32'(wb_en), 32'h1);
    chk("addeq_pass_exe_cmd", 32'(exe_cmd), 32'h2);

    // condition 1111 never passes
    instruction = 32'hF2812003;
    step();
    chk("nv_out_valid", 32'(out_valid), 32'h1);
    chk("nv_wb_en", 32'(wb_en), 32'h0);

    // GT passes and LE fails with N=1, V=1, Z=0
    sr = 4'b1001; instruction = 32'hC2812003;
    step();
    chk("gt_wb_en", 32'(wb_en), 32'h1);
    instruction = 32'hD2812003;
    step();
    chk("le_wb_en", 32'(wb_en), 32'h0);

    // unsupported opcode (RSB) and CMP
    sr = 4'b0000; instruction = 32'hE0612003;
    step();
    chk("rsb_exe_cmd", 32'(exe_cmd), 32'h0);
    chk("rsb_wb_en", 32'(wb_en), 32'h0);
    instruction = 32'hE1512003;  // CMP R1,R3 with S=1
    step();
    chk("cmp_exe_cmd", 32'(exe_cmd), 32'h4);
    chk("cmp_wb_en", 32'(wb_en), 32'h0);
    chk("cmp_s", 32'(s), 32'h1);

    // branch
    instruction = 32'hEA000010;
    step();
    chk("br_b", 32'(b), 32'h1);
    chk("br_exe_cmd", 32'(exe_cmd), 32'h0);
    chk("br_imm24", 32'(signed_imm_24), 32'h10);

    // EX hazard on Rn: bubble, then MEM hazard on Rm: bubble, then load
    instruction = 32'hE0812003; exe_wb_en = 1'b1; exe_dest = 4'd1;
    #1;
    chk("hz_exe_stall", 32'(hazard_stall), 32'h1);
    chk("hz_exe_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("hz_exe_bubble_valid", 32'(out_valid), 32'h0);
    chk("hz_exe_bubble_b", 32'(b), 32'h0);
    exe_wb_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd3;
    #1;
    chk("hz_mem_stall", 32'(hazard_stall), 32'h1);
    step();
    chk("hz_mem_bubble_valid", 32'(out_valid), 32'h0);
    mem_wb_en = 1'b0;
    #1;
    chk("hz_clear_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("add_reg_out_valid", 32'(out_valid), 32'h1);
    chk("add_reg_exe_cmd", 32'(exe_cmd), 32'h2);
    chk("add_reg_val_rn", val_rn, 32'd5);
    chk("add_reg_val_rm", val_rm, 32'd7);
    chk("add_reg_two_src", 32'(two_src), 32'h1);
    chk("add_reg_src2", 32'(src2), 32'd3);

    // MOV does not read Rn, so matching EX dest is not a hazard
    instruction = 32'hE3A10001; exe_wb_en = 1'b1; exe_dest = 4'd1;
    #1;
    chk("mov_no_hazard", 32'(hazard_stall), 32'h0);
    step();
    chk("mov_exe_cmd", 32'(exe_cmd), 32'h1);
    chk("mov_dest", 32'(dest), 32'd0);
    exe_wb_en = 1'b0;

    // downstream backpressure holds the register
    instruction = 32'hE0812003;
    step();
    out_ready = 1'b0; instruction = 32'hE3A10001;
    #1;
    chk("hold_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_out_valid", 32'(out_valid), 32'h1);
      chk("hold_exe_cmd", 32'(exe_cmd), 32'h2);
      chk("hold_val_rm", val_rm, 32'd7);
      chk("hold_in_ready_cyc", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("release_exe_cmd", 32'(exe_cmd), 32'h1);

    // STR R4 with simultaneous write-back of R4 (bypass)
    instruction = 32'hE5814000; wb_en_in = 1'b1; wb_dest = 4'd4; wb_result = 32'hDEAD;
    step();
    wb_en_in = 1'b0;
    chk("str_val_rm", val_rm, 32'hDEAD);
    chk("str_mem_w_en", 32'(mem_w_en), 32'h1);
    chk("str_wb_en", 32'(wb_en), 32'h0);
    chk("str_src2", 32'(src2), 32'd4);
    chk("str_two_src", 32'(two_src), 32'h1);
    chk("str_exe_cmd", 32'(exe_cmd), 32'h2);
    instruction = 32'hE5914000;
    step();
    chk("ldr_mem_r_en", 32'(mem_r_en), 32'h1);
    chk("ldr_wb_en", 32'(wb_en), 32'h1);
    chk("ldr_two_src", 32'(two_src), 32'h0);

    // flush together with a hazard
    instruction = 32'hE0812003; exe_wb_en = 1'b1; exe_dest = 4'd1; flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    chk("flush_hazard", 32'(hazard_stall), 32'h1);
    step();
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_exe_cmd", 32'(exe_cmd), 32'h0);
    flush = 1'b0; exe_wb_en = 1'b0;

    // reset while stalled
    instruction = 32'hE2812003;
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b0; exe_wb_en = 1'b1;
    step();
    chk("stall_held_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_exe_cmd", 32'(exe_cmd), 32'h0);
    chk("async_rst_val_rn", val_rn, 32'h0);
    chk("async_rst_pc_out", pc_out, 32'h0);
    chk("async_rst_dest", 32'(dest), 32'h0);
    exe_wb_en = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("post_rst_out_valid", 32'(out_valid), 32'h1);
    chk("post_rst_rf_cleared", val_rn, 32'h0);
    chk("post_rst_exe_cmd", 32'(exe_cmd), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, datapath/register width; NREG, default 16, register count; RA_W, default $clog2(NREG), register address width.
REQ-002 SHALL have port clk, input, 1, single clock, rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, instruction present; in_ready, output, 1, instruction accepted this cycle.
REQ-005 SHALL have port instruction, input, 32, ARM-format word; pc_in, input, DATA_W, its PC.
REQ-006 SHALL have port sr, input, 4, NZCV flags, N=bit3, Z=bit2, C=bit1, V=bit0.
REQ-007 SHALL have ports wb_en_in (1), wb_dest (RA_W), wb_result (DATA_W), all inputs, write-back port.
REQ-008 SHALL have ports exe_wb_en (1), exe_dest (RA_W), mem_wb_en (1), mem_dest (RA_W), all inputs, downstream destinations for hazard check.
REQ-009 SHALL have port flush, input, 1, kill stage contents and the presented instruction.
REQ-010 SHALL have port out_ready, input, 1, EX accepts; out_valid, output, 1, registered outputs hold a live instruction.
REQ-011 SHALL have registered outputs: wb_en, mem_r_en, mem_w_en, b, s, imm, two_src (1 each); exe_cmd (4); val_rn, val_rm, pc_out (DATA_W); shift_operand (12); signed_imm_24 (24); dest, src1, src2 (RA_W).
REQ-012 SHALL have output hazard_stall, 1, combinational, data hazard detected this cycle.

Function
REQ-013 Decode SHALL be: mode=instr[27:26], opcode=instr[24:21], S=instr[20], imm=instr[25], src1=Rn=instr[19:16], dest=instr[15:12].
REQ-014 Mode 00 exe_cmd SHALL be: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; wb_en=1 except CMP/TST; s=S; any other opcode -> all control 0.
REQ-015 Mode 01 SHALL give exe_cmd 0010; S=1 LDR: mem_r_en=1, wb_en=1; S=0 STR: mem_w_en=1.
REQ-016 Mode 10 SHALL give b=1, all other control 0; mode 11 SHALL give all control 0.
REQ-017 src2 SHALL be instr[15:12] for STR, else instr[3:0]; two_src SHALL be (mode 00 and imm=0) or STR.
REQ-018 Rn SHALL be deemed read unless MOV, MVN or branch.
REQ-019 Condition (instr[31:28]) SHALL evaluate EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL per ARM; 1111 SHALL fail. Failed condition -> control fields 0, out_valid still 1.
REQ-020 hazard_stall SHALL be in_valid and, for X in {exe, mem}: X_wb_en and ((Rn read and X_dest==src1) or (two_src and X_dest==src2)).
REQ-021 in_ready SHALL be flush or (~hazard_stall and (~out_valid or out_ready)).
REQ-022 Latency SHALL be one cycle: on in_valid and in_ready and ~flush, all outputs load and out_valid=1.
REQ-023 On hazard_stall with (~out_valid or out_ready) and ~flush, a bubble SHALL load: out_valid=0, all control 0.
REQ-024 When out_valid=1 and out_ready=0, all outputs SHALL hold.
REQ-025 flush SHALL dominate: next cycle out_valid=0 and control 0; presented instruction dropped.
REQ-026 Register file SHALL write wb_result to wb_dest on the rising edge when wb_en_in; same-cycle read of wb_dest SHALL return wb_result (bypass).
REQ-027 val_rn SHALL be register[src1], val_rm register[src2], both captured at load.

Reset
REQ-028 rst=0 SHALL asynchronously clear every registered output and every register-file entry to 0; out_valid=0.
REQ-029 Reset mid-stall SHALL discard the held instruction; first cycle after release in_ready=1 if no hazard.

Structure
REQ-030 A shared package SHALL hold mode, opcode, exe_cmd and condition-code constants.
REQ-031 Register file SHALL be sub-module reg_file_bypass, parametrised by DATA_W/NREG.
REQ-032 Decode and condition check SHALL be combinational in the top; only the output register and reg_file_bypass hold state.

Verification
REQ-033 WB R1=5, then ADD R2,R1,#3 (0xE2812003), sr=0 -> next cycle exe_cmd=0010, wb_en=1, val_rn=5, dest=2, imm=1, out_valid=1.
REQ-034 ADDEQ with sr=0000 -> out_valid=1, all control 0; sr=0100 -> wb_en=1.
REQ-035 exe_wb_en=1, exe_dest=1, ADD R2,R1,R3 -> hazard_stall=1, in_ready=0, bubble out; exe_wb_en=0 next -> instruction loads.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; out_ready=1 -> next instruction loads.
REQ-037 wb_en_in=1, wb_dest=4, wb_result=0xDEAD same cycle as STR reading R4 -> val_rm=0xDEAD.
REQ-038 flush and hazard together -> in_ready=1, next out_valid=0; rst=0 mid-stall -> all outputs 0 immediately.
